// File: rtl/imem_fetch_ctrl.sv
// imem_fetch_ctrl: single-outstanding instruction fetch FSM (IDLE/REQ/WAIT/HOLD/HALT).
// Define FETCH_PERF_CNT_EN to add saturating fetch_count/stall_count outputs.
module imem_fetch_ctrl #(
  parameter logic [63:0] RESET_PC   = 64'h0,
  parameter logic [63:0] ADDR_LIMIT = 64'h1000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [63:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        imem_rsp_err,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [63:0] branch_target,
  output logic [63:0] PC,
  output logic [31:0] instr,
  output logic        instr_out_valid,
  output logic        imem_error,
  output logic        halted
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
`endif
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, HALT} state_t;
  localparam logic [31:0] NOP = 32'h00000013;
  state_t      state_q, state_d;
  logic [63:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic        addr_ok, accept;
  assign addr_ok = pc_q[1:0] == 2'b00 && pc_q < ADDR_LIMIT;
  assign accept  = state_q == HOLD && !stall;
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    case (state_q)
      IDLE: state_d = REQ;
      REQ:  state_d = !addr_ok ? HALT : imem_req_ready ? WAIT : REQ;
      WAIT: if (imem_rsp_valid) begin
        state_d = imem_rsp_err ? HALT : HOLD;
        instr_d = imem_rsp_err ? instr_q : imem_rsp_data;
      end
      HOLD: if (accept) begin
        state_d = REQ;
        pc_d    = branch_taken ? branch_target : pc_q + 64'd4;
      end
      // HALT and unused encodings stay halted until reset
      default: state_d = HALT;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      instr_q <= NOP;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
    end
  end
  assign imem_req_valid  = state_q == REQ && addr_ok;
  assign imem_addr       = pc_q;
  assign PC              = pc_q;
  assign instr           = instr_q;
  assign instr_out_valid = state_q == HOLD;
  assign imem_error      = state_q == HALT;
  assign halted          = state_q == HALT;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count_q, fetch_count_d, stall_count_q, stall_count_d;
  always_comb begin
    fetch_count_d = (accept && fetch_count_q != '1) ? fetch_count_q + 32'd1 : fetch_count_q;
    stall_count_d = (state_q == HOLD && stall && stall_count_q != '1) ? stall_count_q + 32'd1 : stall_count_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count_q <= '0;
      stall_count_q <= '0;
    end else begin
      fetch_count_q <= fetch_count_d;
      stall_count_q <= stall_count_d;
    end
  end
  assign fetch_count = fetch_count_q;
  assign stall_count = stall_count_q;
`endif
endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// tb_imem_fetch_ctrl: randomized scoreboard bench; a reactive memory/consumer model predicts
// the fetch address stream and PC/instr pairs, a separate monitor checks them.
module tb_imem_fetch_ctrl;
  localparam logic [63:0] RST_PC = 64'h0;
  localparam logic [63:0] LIMIT  = 64'h1000;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        imem_req_valid, imem_req_ready = 1'b0;
  logic [63:0] imem_addr;
  logic        imem_rsp_valid = 1'b0, imem_rsp_err = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        stall = 1'b0, branch_taken = 1'b0;
  logic [63:0] branch_target = '0;
  logic [63:0] PC;
  logic [31:0] instr;
  logic        instr_out_valid, imem_error, halted;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count, stall_count, e_fc, e_sc;
`endif
  always #5 clk = ~clk;
  imem_fetch_ctrl #(.RESET_PC(RST_PC), .ADDR_LIMIT(LIMIT)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data), .imem_rsp_err(imem_rsp_err),
    .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .PC(PC), .instr(instr), .instr_out_valid(instr_out_valid),
    .imem_error(imem_error), .halted(halted)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fetch_count), .stall_count(stall_count)
`endif
  );
  typedef struct {logic [63:0] pc; bit tk; logic [63:0] tgt;} br_t;
  int          n_chk = 0, n_fail = 0, cyc = 0, lat = 0, burst = 0, halt_lat = 0;
  logic [63:0] exp_addr_q[$];
  logic [95:0] exp_out_q[$];
  br_t         br_q[$];
  logic [31:0] data_q[$];
  bit          err_q[$];
  int          out_t[$];
  logic [63:0] m_pc = RST_PC, halt_pc = '0, stall_pc = '1;
  bit          pending = 0, exp_halt = 0, dir = 0, have_cur = 0, cur_ok = 0;
  logic [95:0] cur = '0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] rnd_tgt();
    int k = $urandom_range(0, 31);
    logic [63:0] t = 64'($urandom_range(0, 1023)) << 2;
    if (k == 0) return LIMIT;
    if (k == 1) return t | 64'd2;
    if (k == 2) return {32'($urandom), 32'($urandom)} | 64'h1_0000_0000;
    return t;
  endfunction

  // Monitor: samples after the driver has settled inputs for the coming edge
  always @(negedge clk) begin
    #2;
    cyc++;
    if (!rst_n) begin
      have_cur = 0;
`ifdef FETCH_PERF_CNT_EN
      e_fc = '0;
      e_sc = '0;
`endif
    end else begin
      if (!exp_halt) begin
        chk("no_spurious_halt", 64'(halted), 64'd0);
        chk("no_spurious_err", 64'(imem_error), 64'd0);
      end
`ifdef FETCH_PERF_CNT_EN
      chk("fetch_count", 64'(fetch_count), 64'(e_fc));
      chk("stall_count", 64'(stall_count), 64'(e_sc));
`endif
      if (imem_req_valid && imem_req_ready) begin
        if (exp_addr_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL req_unexpected: got request at %h expected none", imem_addr);
        end else chk("req_addr", imem_addr, exp_addr_q.pop_front());
      end
      if (instr_out_valid) begin
        chk("req_during_hold", 64'(imem_req_valid), 64'd0);
        if (!have_cur) begin
          have_cur = 1;
          out_t.push_back(cyc);
          cur_ok = exp_out_q.size() != 0;
          if (cur_ok) cur = exp_out_q.pop_front();
          else begin
            n_chk++; n_fail++;
            $display("FAIL out_unexpected: got pc %h instr %h expected no output", PC, instr);
          end
        end
        if (cur_ok) begin
          chk("out_pc", PC, cur[95:32]);
          chk("out_instr", 64'(instr), 64'(cur[31:0]));
        end
        if (!stall) have_cur = 0;
`ifdef FETCH_PERF_CNT_EN
        if (stall && e_sc != '1) e_sc++;
        if (!stall && e_fc != '1) e_fc++;
`endif
      end
    end
  end

  // Driver: memory that answers accepted requests, plus a downstream consumer
  task automatic step();
    logic [63:0] nxt;
    @(negedge clk); #1;
    imem_req_ready = dir ? 1'b1 : ($urandom_range(0, 3) != 0);
    imem_rsp_valid = 1'b0;
    imem_rsp_err   = 1'($urandom_range(0, 1));
    imem_rsp_data  = $urandom;
    if (pending) begin
      if (lat == 0) begin
        pending = 0;
        imem_rsp_valid = 1'b1;
        if (data_q.size() != 0) imem_rsp_data = data_q.pop_front();
        if (err_q.size() != 0) imem_rsp_err = err_q.pop_front();
        else imem_rsp_err = !dir && $urandom_range(0, 39) == 0;
        if (imem_rsp_err) begin
          exp_halt = 1; halt_pc = m_pc; halt_lat = 1;
        end else exp_out_q.push_back({m_pc, imem_rsp_data});
      end else lat--;
    end else if (!dir) imem_rsp_valid = $urandom_range(0, 4) == 0;
    if (imem_req_valid && imem_req_ready) begin
      pending = 1;
      lat = dir ? 0 : int'($urandom_range(0, 3));
    end
    stall = dir ? (instr_out_valid && m_pc == stall_pc && burst > 0) : ($urandom_range(0, 2) == 0);
    if (dir && stall) burst--;
    branch_taken  = $urandom_range(0, 3) == 0;
    branch_target = rnd_tgt();
    if (dir && instr_out_valid) begin
      branch_taken = 1'b0;
      if (!stall && br_q.size() != 0 && br_q[0].pc == m_pc) begin
        branch_taken  = br_q[0].tk;
        branch_target = br_q[0].tgt;
        void'(br_q.pop_front());
      end
    end
    if (instr_out_valid && !stall) begin
      nxt = branch_taken ? branch_target : m_pc + 64'd4;
      m_pc = nxt;
      if (nxt[1:0] == 2'b00 && nxt < LIMIT) exp_addr_q.push_back(nxt);
      else begin
        exp_halt = 1; halt_pc = nxt; halt_lat = 2;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    rst_n = 1'b0;
    dir = 0; pending = 0; exp_halt = 0; m_pc = RST_PC; burst = 0; stall_pc = '1;
    exp_addr_q.delete(); exp_out_q.delete(); br_q.delete(); data_q.delete(); err_q.delete(); out_t.delete();
    imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; stall = 1'b0; branch_taken = 1'b0;
    #1;
    chk("rst_pc", PC, RST_PC);
    chk("rst_instr", 64'(instr), 64'h13);
    chk("rst_out_valid", 64'(instr_out_valid), 64'd0);
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_imem_error", 64'(imem_error), 64'd0);
    chk("rst_halted", 64'(halted), 64'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst_fetch_count", 64'(fetch_count), 64'd0);
    chk("rst_stall_count", 64'(stall_count), 64'd0);
`endif
    @(negedge clk); #1;
    rst_n = 1'b1;
    exp_addr_q.push_back(RST_PC);
    chk("idle_no_req", 64'(imem_req_valid), 64'd0);
  endtask

  task automatic wait_halt(input logic [63:0] pc);
    int n = 0;
    while (!halted && n < 12) begin
      step();
      n++;
    end
    chk("halt_latency", 64'(n), 64'(halt_lat));
    for (int i = 0; i < 4; i++) begin
      step();
      chk("halt_sticky", 64'(halted), 64'd1);
      chk("halt_imem_error", 64'(imem_error), 64'd1);
      chk("halt_req_valid", 64'(imem_req_valid), 64'd0);
      chk("halt_out_valid", 64'(instr_out_valid), 64'd0);
      chk("halt_pc_frozen", PC, pc);
    end
  endtask

  task automatic run_until_halt(input int budget);
    for (int i = 0; i < budget && !exp_halt; i++) step();
    chk("halt_expected", 64'(exp_halt), 64'd1);
  endtask

  initial begin
    // Directed stream: first fetch, taken/not-taken redirects, stall burst, throughput
    do_reset();
    dir = 1; stall_pc = 64'h8; burst = 3;
    data_q.push_back(32'h002081B3);
    br_q.push_back('{pc: 64'h18, tk: 1'b1, tgt: 64'h38});
    br_q.push_back('{pc: 64'h38, tk: 1'b1, tgt: 64'h18});
    br_q.push_back('{pc: 64'h18, tk: 1'b0, tgt: 64'h38});
    step();
    chk("first_req_valid", 64'(imem_req_valid), 64'd1);
    chk("first_req_addr", imem_addr, RST_PC);
    for (int i = 0; i < 45; i++) step();
    chk("branch_script_done", 64'(br_q.size()), 64'd0);
    chk("out_count", 64'(out_t.size() >= 4), 64'd1);
    if (out_t.size() >= 4) begin
      chk("throughput_0_4", 64'(out_t[1] - out_t[0]), 64'd3);
      chk("throughput_4_8", 64'(out_t[2] - out_t[1]), 64'd3);
      chk("stall_3_cycles", 64'(out_t[3] - out_t[2]), 64'd6);
    end
    // Illegal redirect targets
    do_reset();
    dir = 1;
    br_q.push_back('{pc: 64'h0, tk: 1'b1, tgt: 64'h1000});
    run_until_halt(30);
    wait_halt(64'h1000);
    do_reset();
    dir = 1;
    br_q.push_back('{pc: 64'h4, tk: 1'b1, tgt: 64'h2});
    run_until_halt(30);
    wait_halt(64'h2);
    // Error response halts at the faulting PC
    do_reset();
    dir = 1;
    err_q.push_back(1'b0);
    err_q.push_back(1'b1);
    run_until_halt(30);
    wait_halt(64'h4);
    // Reset mid-WAIT, then a late response during IDLE must be ignored
    do_reset();
    dir = 1;
    for (int i = 0; i < 40 && !(m_pc == 64'hC && pending); i++) step();
    chk("reached_wait_at_c", 64'(pending), 64'd1);
    do_reset();
    imem_rsp_valid = 1'b1; imem_rsp_data = 32'hDEADBEEF; imem_rsp_err = 1'b1;
    dir = 1;
    for (int i = 0; i < 12; i++) step();
    chk("post_reset_fetches", 64'(out_t.size() >= 2), 64'd1);
    // Random episodes
    for (int e = 0; e < 12; e++) begin
      do_reset();
      for (int i = 0; i < 300 && !exp_halt; i++) step();
      if (exp_halt) wait_halt(halt_pc);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
